fnd_periph_mx: RTL and testbench

- APB slave that drives an N-digit multiplexed 7-segment display (common anode, active-low font and commons).
- Adds over the single-format 4-digit peripheral: parametrised digit count, per-digit decimal point, per-digit blink, leading-zero blanking and PWM brightness.
- Sits on the APB bus beside the other peripherals; its outputs go straight to the board FND pins.

---
 rtl/fnd_pkg.sv | 35 +++
 rtl/fnd_periph_mx_if.sv | 25 ++
 rtl/fnd_scan_timer.sv | 96 +++++++++
 rtl/fnd_periph_mx.sv | 158 +++++++++++++++
 tb/tb_fnd_periph_mx.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
// Shared constants for the multiplexed 7-segment display peripheral:
//   - APB register offsets (PADDR[3:2] values)
//   - CTRL bit indices
//   - 16-entry glyph table (segments {g,f,e,d,c,b,a}, active-low) and lookup
// -----------------------------------------------------------------------------
package fnd_pkg;

   // Register selectors, i.e. byte offset >> 2
   localparam logic [1:0] REG_DATA   = 2'd0;   // 0x0
   localparam logic [1:0] REG_CTRL   = 2'd1;   // 0x4
   localparam logic [1:0] REG_MASK   = 2'd2;   // 0x8
   localparam logic [1:0] REG_BRIGHT = 2'd3;   // 0xC

   // CTRL register layout
   localparam int CTRL_EN    = 0;
   localparam int CTRL_LZB   = 1;
   localparam int CTRL_BLINK = 2;
   localparam int CTRL_W     = 3;

   // Bit position of the BLINK field inside MASK
   localparam int MASK_BLINK_LSB = 16;

   // Active-low glyphs: 0-9, then L r S t o P for A-F
   localparam logic [6:0] GLYPH_TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h47, 7'h2F, 7'h12, 7'h07, 7'h23, 7'h0C
   };

   function automatic logic [6:0] fnd_glyph(input logic [3:0] nibble);
      return GLYPH_TBL[nibble];
   endfunction

endpackage

// File: rtl/fnd_periph_mx_if.sv
// -----------------------------------------------------------------------------
// fnd_periph_mx_if
// APB bus bundle for the display peripheral.
//   master modport: drives PADDR/PWDATA/PWRITE/PENABLE/PSEL, samples PRDATA/PREADY
//   slave  modport: the reverse
// -----------------------------------------------------------------------------
interface fnd_periph_mx_if;
   logic [3:0]  PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PENABLE;
   logic        PSEL;
   logic [31:0] PRDATA;
   logic        PREADY;

   modport master (
      output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
      output PRDATA, PREADY
   );
endinterface

// File: rtl/fnd_scan_timer.sv
// -----------------------------------------------------------------------------
// fnd_scan_timer
// Digit-scan timebase: prescaler -> 16-phase PWM counter -> digit select,
// plus a blink counter stepped once per digit slot.
// Ports:
//   PCLK, PRESET  clock, async active-low reset
//   run_i         1 = counting; 0 = all counters forced to 0
//   sel_o         digit currently being scanned (0..N_DIGITS-1)
//   ph_o          PWM phase within the slot (0..15)
//   blink_ph_o    blink half-period indicator (1 = blink-off half)
// -----------------------------------------------------------------------------
module fnd_scan_timer #(
   parameter  int N_DIGITS    = 4,
   parameter  int SCAN_DIV    = 100_000,
   parameter  int BLINK_SLOTS = 250,
   localparam int SEL_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic             run_i,
   output logic [SEL_W-1:0] sel_o,
   output logic [3:0]       ph_o,
   output logic             blink_ph_o
);

   localparam int PRE_MAX = SCAN_DIV / 16;
   localparam int PRE_W   = $clog2(PRE_MAX);
   localparam int BLK_W   = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_MAX - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_DIGITS - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_SLOTS - 1);

   logic [PRE_W-1:0] pre_q,  pre_d;
   logic [3:0]       ph_q,   ph_d;
   logic [SEL_W-1:0] sel_q,  sel_d;
   logic [BLK_W-1:0] bcnt_q, bcnt_d;
   logic             bph_q,  bph_d;

   logic pre_wrap;
   logic slot_end;

   assign pre_wrap = (pre_q == PRE_LAST);
   assign slot_end = pre_wrap && (ph_q == 4'hF);

   always_comb begin
      pre_d  = pre_q;
      ph_d   = ph_q;
      sel_d  = sel_q;
      bcnt_d = bcnt_q;
      bph_d  = bph_q;
      if (!run_i) begin
         // Held at zero so that enabling always starts at digit 0, phase 0
         pre_d  = '0;
         ph_d   = '0;
         sel_d  = '0;
         bcnt_d = '0;
         bph_d  = 1'b0;
      end else begin
         pre_d = pre_wrap ? '0 : pre_q + 1'b1;
         if (pre_wrap) begin
            ph_d = ph_q + 4'd1;   // 15 -> 0 wraps naturally at slot end
         end
         if (slot_end) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            if (bcnt_q == BLK_LAST) begin
               bcnt_d = '0;
               bph_d  = ~bph_q;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         pre_q  <= '0;
         ph_q   <= '0;
         sel_q  <= '0;
         bcnt_q <= '0;
         bph_q  <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         ph_q   <= ph_d;
         sel_q  <= sel_d;
         bcnt_q <= bcnt_d;
         bph_q  <= bph_d;
      end
   end

   assign sel_o      = sel_q;
   assign ph_o       = ph_q;
   assign blink_ph_o = bph_q;

endmodule

// File: rtl/fnd_periph_mx.sv
// -----------------------------------------------------------------------------
// fnd_periph_mx
// APB slave driving an N-digit multiplexed common-anode 7-segment display with
// per-digit decimal point, per-digit blink, leading-zero blanking and 16-step
// PWM brightness.
// Ports:
//   PCLK, PRESET  clock, async active-low reset
//   apb           APB slave port (one wait state per transfer)
//   fndFont       segments {dp,g,f,e,d,c,b,a}, active-low
//   fndComm       digit commons, active-low; bit 0 = rightmost digit
// -----------------------------------------------------------------------------
module fnd_periph_mx
   import fnd_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int SCAN_DIV    = 100_000,
   parameter int BLINK_SLOTS = 250
) (
   input  logic                PCLK,
   input  logic                PRESET,
   fnd_periph_mx_if.slave      apb,
   output logic [7:0]          fndFont,
   output logic [N_DIGITS-1:0] fndComm
);

   localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [N_DIGITS-1:0] DIGIT0_ON = N_DIGITS'(1);

   // ---------------- register file ----------------
   logic [4*N_DIGITS-1:0] data_q,   data_d;
   logic [CTRL_W-1:0]     ctrl_q,   ctrl_d;
   logic [N_DIGITS-1:0]   dp_q,     dp_d;
   logic [N_DIGITS-1:0]   blink_q,  blink_d;
   logic [3:0]            bright_q, bright_d;
   logic                  pready_q, pready_d;
   logic [31:0]           prdata_q, prdata_d;
   logic                  served_q, served_d;

   logic        access;
   logic        commit;
   logic [31:0] rdata;
   logic        unused_apb;

   assign access = apb.PSEL && apb.PENABLE;
   // One commit per continuous access phase: a master that keeps PSEL/PENABLE
   // high past PREADY does not start a second transfer.
   assign commit = access && !served_q;

   assign unused_apb = ^{apb.PADDR[1:0], apb.PWDATA};

   always_comb begin
      rdata = '0;
      case (apb.PADDR[3:2])
         REG_DATA: rdata[4*N_DIGITS-1:0] = data_q;
         REG_CTRL: rdata[CTRL_W-1:0]     = ctrl_q;
         REG_MASK: begin
            rdata[N_DIGITS-1:0]                 = dp_q;
            rdata[MASK_BLINK_LSB +: N_DIGITS]   = blink_q;
         end
         default:  rdata[3:0]            = bright_q;
      endcase
   end

   always_comb begin
      data_d   = data_q;
      ctrl_d   = ctrl_q;
      dp_d     = dp_q;
      blink_d  = blink_q;
      bright_d = bright_q;
      pready_d = commit;
      prdata_d = (commit && !apb.PWRITE) ? rdata : '0;
      served_d = access;
      if (commit && apb.PWRITE) begin
         case (apb.PADDR[3:2])
            REG_DATA: data_d = apb.PWDATA[4*N_DIGITS-1:0];
            REG_CTRL: ctrl_d = apb.PWDATA[CTRL_W-1:0];
            REG_MASK: begin
               dp_d    = apb.PWDATA[N_DIGITS-1:0];
               blink_d = apb.PWDATA[MASK_BLINK_LSB +: N_DIGITS];
            end
            default:  bright_d = apb.PWDATA[3:0];
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         data_q   <= '0;
         ctrl_q   <= '0;
         dp_q     <= '0;
         blink_q  <= '0;
         bright_q <= '0;
         pready_q <= 1'b0;
         prdata_q <= '0;
         served_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         ctrl_q   <= ctrl_d;
         dp_q     <= dp_d;
         blink_q  <= blink_d;
         bright_q <= bright_d;
         pready_q <= pready_d;
         prdata_q <= prdata_d;
         served_q <= served_d;
      end
   end

   assign apb.PREADY = pready_q;
   assign apb.PRDATA = prdata_q;

   // ---------------- scan timebase ----------------
   logic [SEL_W-1:0] sel;
   logic [3:0]       ph;
   logic             blink_ph;
   logic             run;

   // Counters run only while EN is set now and after this edge, so a write
   // clearing EN zeroes them on the commit edge itself, and a write setting
   // EN leaves them at zero for the first displayed cycle.
   assign run = ctrl_q[CTRL_EN] && ctrl_d[CTRL_EN];

   fnd_scan_timer #(
      .N_DIGITS    (N_DIGITS),
      .SCAN_DIV    (SCAN_DIV),
      .BLINK_SLOTS (BLINK_SLOTS)
   ) u_scan (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .run_i      (run),
      .sel_o      (sel),
      .ph_o       (ph),
      .blink_ph_o (blink_ph)
   );

   // ---------------- blanking / mux ----------------
   // upper_zero[i]: nibbles i..N_DIGITS-1 are all zero
   logic [N_DIGITS-1:0] upper_zero;

   for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lzb
      assign upper_zero[gi] = (data_q[4*N_DIGITS-1:4*gi] == '0);
   end

   logic [3:0] nibble;
   logic       lzb_blank;
   logic       blink_blank;
   logic       pwm_off;
   logic       blank;

   assign nibble      = data_q[4*sel +: 4];
   assign lzb_blank   = ctrl_q[CTRL_LZB] && (sel != '0) && upper_zero[sel];
   assign blink_blank = ctrl_q[CTRL_BLINK] && blink_q[sel] && blink_ph;
   assign pwm_off     = (ph > bright_q);
   assign blank       = !ctrl_q[CTRL_EN] || lzb_blank || blink_blank || pwm_off;

   assign fndComm = blank ? '1 : ~(DIGIT0_ON << sel);
   assign fndFont = blank ? 8'hFF : {~dp_q[sel], fnd_glyph(nibble)};

endmodule

// File: tb/tb_fnd_periph_mx.sv
// -----------------------------------------------------------------------------
// tb_fnd_periph_mx
// Directed bench for fnd_periph_mx (N_DIGITS=4, SCAN_DIV=32, BLINK_SLOTS=2).
// A transfer-level / time-based model predicts every output on every cycle;
// literal expectations pin the model at key points of the sequence.
// -----------------------------------------------------------------------------
module tb_fnd_periph_mx;

   localparam int N   = 4;
   localparam int SD  = 32;
   localparam int BS  = 2;
   localparam int PRE = SD / 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fnd_periph_mx_if bus();
   logic [7:0] font;
   logic [3:0] comm;

   fnd_periph_mx #(
      .N_DIGITS    (N),
      .SCAN_DIV    (SD),
      .BLINK_SLOTS (BS)
   ) dut (
      .PCLK    (clk),
      .PRESET  (rst_n),
      .apb     (bus),
      .fndFont (font),
      .fndComm (comm)
   );

   int vectors     = 0;
   int miscompares = 0;
   int nprint      = 0;
   logic checking  = 1'b0;

   // ---------------- behavioural model ----------------
   logic [6:0] gl_tbl [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h47, 7'h2F, 7'h12, 7'h07, 7'h23, 7'h0C
   };

   logic [15:0] m_data;
   logic [2:0]  m_ctrl;
   logic [3:0]  m_dp, m_blink, m_bright;
   logic        m_ready, m_in_access;
   logic [31:0] m_rdata;
   int          m_t;      // cycles elapsed since the display was (re)enabled

   function automatic logic [31:0] model_read(input logic [1:0] r);
      case (r)
         2'd0:    return {16'h0, m_data};
         2'd1:    return {29'h0, m_ctrl};
         2'd2:    return {12'h0, m_blink, 12'h0, m_dp};
         default: return {28'h0, m_bright};
      endcase
   endfunction

   // Display state derived purely from elapsed time since enable
   function automatic void model_out(output logic [3:0] ec, output logic [7:0] ef);
      int k, sel, ph, bph;
      logic [15:0] up;
      logic blank;
      k   = m_t / SD;
      sel = k % N;
      ph  = (m_t % SD) / PRE;
      bph = (k / BS) % 2;
      up  = m_data >> (4 * sel);
      blank = !m_ctrl[0]
           || (m_ctrl[1] && sel > 0 && up == 16'h0)
           || (m_ctrl[2] && m_blink[sel] && bph == 1)
           || (ph > int'(m_bright));
      if (blank) begin
         ec = 4'hF;
         ef = 8'hFF;
      end else begin
         ec = ~(4'b0001 << sel);
         ef = {~m_dp[sel], gl_tbl[up[3:0]]};
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic acc, first;
      logic [2:0] nctrl;
      if (!rst_n) begin
         m_data = '0; m_ctrl = '0; m_dp = '0; m_blink = '0; m_bright = '0;
         m_ready = 1'b0; m_in_access = 1'b0; m_rdata = '0; m_t = 0;
      end else begin
         acc   = bus.PSEL && bus.PENABLE;
         first = acc && !m_in_access;   // first cycle of an access phase
         nctrl = m_ctrl;
         if (first && bus.PWRITE && bus.PADDR[3:2] == 2'd1) nctrl = bus.PWDATA[2:0];
         m_t = (m_ctrl[0] && nctrl[0]) ? m_t + 1 : 0;
         m_rdata = (first && !bus.PWRITE) ? model_read(bus.PADDR[3:2]) : 32'h0;
         m_ready = first;
         m_in_access = acc;
         if (first && bus.PWRITE) begin
            case (bus.PADDR[3:2])
               2'd0: m_data = bus.PWDATA[15:0];
               2'd1: m_ctrl = bus.PWDATA[2:0];
               2'd2: begin m_dp = bus.PWDATA[3:0]; m_blink = bus.PWDATA[19:16]; end
               default: m_bright = bus.PWDATA[3:0];
            endcase
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [3:0] ec;
      logic [7:0] ef;
      if (checking) begin
         model_out(ec, ef);
         vectors++;
         if (comm !== ec || font !== ef || bus.PREADY !== m_ready || bus.PRDATA !== m_rdata) begin
            miscompares++;
            if (nprint < 20) begin
               nprint++;
               $display("FAIL cycle_model @%0t: got comm=%b font=%h ready=%b rdata=%h, want comm=%b font=%h ready=%b rdata=%h",
                        $time, comm, font, bus.PREADY, bus.PRDATA, ec, ef, m_ready, m_rdata);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                           input int hold, output logic [31:0] rd, output int pulses);
      int n;
      rd = '0;
      pulses = 0;
      n = 0;
      @(posedge clk); #1;
      bus.PSEL = 1'b1; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wd; bus.PENABLE = 1'b0;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      while (n < 8) begin
         @(posedge clk); #1;
         n++;
         if (bus.PREADY === 1'b1) begin
            pulses++;
            rd = bus.PRDATA;
         end
         if (pulses > 0 && n >= hold) break;
      end
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      if (pulses == 0) lit("apb_timeout", 32'h0, 32'h1);
      $display("apb %s addr=%h wdata=%h rdata=%h pready_pulses=%0d",
               wr ? "wr" : "rd", addr, wd, rd, pulses);
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      int p;
      apb_xfer(1'b1, addr, wd, 1, rd, p);
   endtask

   // Poll on falling edges until fndComm equals want (bounded)
   task automatic wait_comm(input logic [3:0] want, input int limit, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (comm !== want && n < limit);
      lit(name, {28'h0, comm}, {28'h0, want});
   endtask

   // Number of consecutive falling edges (including the current one) showing want
   task automatic run_len(input logic [3:0] want, output int len);
      len = 1;
      while (len < 200) begin
         @(negedge clk);
         if (comm !== want) break;
         len++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd;
      int p, len, c0, c2;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0; bus.PWDATA = '0;

      repeat (3) @(posedge clk);
      checking = 1'b1;
      #1 rst_n = 1'b1;
      repeat (100) @(posedge clk);
      @(negedge clk);
      lit("reset_comm",   {28'h0, comm}, 32'hF);
      lit("reset_font",   {24'h0, font}, 32'hFF);
      lit("reset_pready", {31'h0, bus.PREADY}, 32'h0);

      apb_xfer(1'b0, 4'h4, 32'h0, 3, rd, p);
      lit("rd_ctrl_reset", rd, 32'h0);
      lit("rd_pready_pulses", p, 32'd1);

      // Normal scan of 0x1234 at full brightness
      wr(4'h0, 32'h0000_1234);
      wr(4'hC, 32'h0000_000F);
      wr(4'h4, 32'h0000_0001);
      wait_comm(4'b1110, 64, "scan_d0_comm");
      lit("scan_d0_font", {24'h0, font}, 32'h99);
      wait_comm(4'b1101, 64, "scan_d1_comm");
      lit("scan_d1_font", {24'h0, font}, 32'hB0);
      run_len(4'b1101, len);
      lit("slot_len", len, 32'd32);
      lit("scan_d2_comm", {28'h0, comm}, 32'hB);
      lit("scan_d2_font", {24'h0, font}, 32'hA4);
      wait_comm(4'b0111, 40, "scan_d3_comm");
      lit("scan_d3_font", {24'h0, font}, 32'hF9);
      wait_comm(4'b1110, 40, "scan_wrap_comm");

      // Leading-zero blanking
      wr(4'h0, 32'h0000_0007);
      wr(4'h4, 32'h0000_0003);
      wait_comm(4'b1110, 200, "lzb_d0_comm");
      lit("lzb_d0_font", {24'h0, font}, 32'hF8);
      c0 = 0;
      for (int i = 0; i < 4 * SD; i++) begin
         @(negedge clk);
         if (comm !== 4'hF) c0++;
      end
      lit("lzb_lit_cycles", c0, 32'd32);
      wr(4'h0, 32'h0000_0000);
      wait_comm(4'b1110, 200, "zero_d0_comm");
      lit("zero_d0_font", {24'h0, font}, 32'hC0);

      // PWM brightness 3
      wr(4'h0, 32'h0000_1234);
      wr(4'h4, 32'h0000_0001);
      wr(4'hC, 32'h0000_0003);
      wait_comm(4'b1101, 200, "pwm_d1_comm");
      wait_comm(4'b1011, 200, "pwm_d2_comm");
      run_len(4'b1011, len);
      lit("pwm_on_len", len, 32'd8);
      run_len(4'b1111, len);
      lit("pwm_off_len", len, 32'd24);
      lit("pwm_next_comm", {28'h0, comm}, 32'h7);
      wr(4'hC, 32'h0000_000F);

      // Restart at digit 0 when re-enabled
      wr(4'h4, 32'h0000_0000);
      wr(4'h4, 32'h0000_0001);
      lit("restart_comm", {28'h0, comm}, 32'hE);

      // MASK read-back, held access phase, decimal point and blink
      wr(4'h8, 32'hFFF5_FFF2);
      apb_xfer(1'b0, 4'h8, 32'h0, 1, rd, p);
      lit("rd_mask", rd, 32'h0005_0002);
      apb_xfer(1'b1, 4'h4, 32'h0000_0005, 4, rd, p);
      lit("held_pready_pulses", p, 32'd1);
      apb_xfer(1'b0, 4'h4, 32'h0, 1, rd, p);
      lit("rd_ctrl_blink", rd, 32'h5);
      wait_comm(4'b1101, 200, "dp_d1_comm");
      lit("dp_d1_font", {24'h0, font}, 32'h30);
      c0 = 0;
      c2 = 0;
      for (int i = 0; i < 8 * SD; i++) begin
         @(negedge clk);
         if (comm === 4'b1110) c0++;
         if (comm === 4'b1011) c2++;
      end
      lit("blink_d0_lit", c0, 32'd64);
      lit("blink_d2_lit", c2, 32'd0);

      // Asynchronous reset mid-scan
      wait_comm(4'b1110, 200, "pre_reset_comm");
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      lit("async_rst_comm", {28'h0, comm}, 32'hF);
      lit("async_rst_font", {24'h0, font}, 32'hFF);
      lit("async_rst_pready", {31'h0, bus.PREADY}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      apb_xfer(1'b0, 4'h0, 32'h0, 1, rd, p);
      lit("post_rst_data", rd, 32'h0);
      apb_xfer(1'b0, 4'h4, 32'h0, 1, rd, p);
      lit("post_rst_ctrl", rd, 32'h0);
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
